// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 16x4 data RAM.
// Each granted access takes IDLE -> ACCESS -> RESP with all RAM pins driven from flops.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   last;
  logic   win;

  logic              win_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  // Winner pick: a lone requester wins; on contention the port not served last wins.
  always_comb begin
    win_c       = (req0 && req1) ? ~last : req1;
    sel_we_c    = win_c ? we1    : we0;
    sel_addr_c  = win_c ? addr1  : addr0;
    sel_wdata_c = win_c ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      win          <= 1'b0;
      busy         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      ram_cs       <= 1'b0;
      ram_write_en <= 1'b1;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win          <= win_c;
            last         <= win_c;
            ram_cs       <= 1'b1;
            ram_write_en <= ~sel_we_c;
            ram_addr     <= sel_addr_c;
            ram_wdata    <= sel_wdata_c;
            busy         <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          // write_en high here means a read: capture RAM output at the end of the access.
          if (ram_write_en) begin
            if (win) rdata1 <= ram_rdata;
            else     rdata0 <= ram_rdata;
          end
          if (win) done1 <= 1'b1;
          else     done0 <= 1'b1;
          ram_cs       <= 1'b0;
          ram_write_en <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x4 RAM (async read, clocked write).
module tb_ram_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, done1, busy;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ram_cs, ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int vectors     = 0;
  int miscompares = 0;

  bit [3:0] mem [16];

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
    .busy(busy), .ram_cs(ram_cs), .ram_write_en(ram_write_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: write_en is active low and only acts with cs asserted.
  always @(posedge clk) if (ram_cs && !ram_write_en) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_cs"}, ram_cs, 1'b0);
    chk1({tag, "_we"}, ram_write_en, 1'b1);
    chk4({tag, "_addr"}, ram_addr, 4'h0);
    chk4({tag, "_wdata"}, ram_wdata, 4'h0);
    chk1({tag, "_done0"}, done0, 1'b0);
    chk1({tag, "_done1"}, done1, 1'b0);
    chk4({tag, "_rdata0"}, rdata0, 4'h0);
    chk4({tag, "_rdata1"}, rdata1, 4'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_cs"}, ram_cs, 1'b0);
    chk1({tag, "_we"}, ram_write_en, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done0"}, done0, 1'b0);
    chk1({tag, "_done1"}, done1, 1'b0);
  endtask

  // Entered just after a negedge with the DUT idle; returns after the following IDLE negedge.
  task automatic do_access(input string tag, input bit p, input logic we, input logic [3:0] a,
                           input logic [3:0] d, input logic [3:0] exp_rd);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    @(negedge clk);
    chk1({tag, "_acc_cs"}, ram_cs, 1'b1);
    chk1({tag, "_acc_we"}, ram_write_en, ~we);
    chk4({tag, "_acc_addr"}, ram_addr, a);
    if (we) chk4({tag, "_acc_wdata"}, ram_wdata, d);
    chk1({tag, "_acc_busy"}, busy, 1'b1);
    chk1({tag, "_acc_done0"}, done0, 1'b0);
    chk1({tag, "_acc_done1"}, done1, 1'b0);
    @(negedge clk);
    chk1({tag, "_rsp_cs"}, ram_cs, 1'b0);
    chk1({tag, "_rsp_we"}, ram_write_en, 1'b1);
    chk1({tag, "_rsp_busy"}, busy, 1'b1);
    chk1({tag, "_rsp_done0"}, done0, ~p);
    chk1({tag, "_rsp_done1"}, done1, p);
    chk4({tag, "_rsp_rdata"}, p ? rdata1 : rdata0, exp_rd);
    if (p) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    chk_idle({tag, "_idle"});
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_por");

    // Simultaneous requests from reset: port 0 wins first because last resets to 1.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'h1; wdata1 = 4'h7;
    @(negedge clk);
    chk1("sim_acc0_cs", ram_cs, 1'b1);
    chk1("sim_acc0_we", ram_write_en, 1'b1);
    chk4("sim_acc0_addr", ram_addr, 4'h1);
    @(negedge clk);
    chk1("sim_rsp0_done0", done0, 1'b1);
    chk1("sim_rsp0_done1", done1, 1'b0);
    chk4("sim_rsp0_rdata0", rdata0, 4'h0);
    req0 = 1'b0;
    @(negedge clk);
    chk_idle("sim_idle0");
    @(negedge clk);
    chk1("sim_acc1_cs", ram_cs, 1'b1);
    chk1("sim_acc1_we", ram_write_en, 1'b0);
    chk4("sim_acc1_addr", ram_addr, 4'h1);
    chk4("sim_acc1_wdata", ram_wdata, 4'h7);
    @(negedge clk);
    chk1("sim_rsp1_done1", done1, 1'b1);
    chk1("sim_rsp1_done0", done0, 1'b0);
    chk4("sim_rsp1_rdata1", rdata1, 4'h0);
    req1 = 1'b0;
    @(negedge clk);
    chk_idle("sim_idle1");
    do_access("sim_rdback", 1'b0, 1'b0, 4'h1, 4'h0, 4'h7);

    // Port 0 write then read; rdata0 holds its old value across the write.
    do_access("p0_wr3", 1'b0, 1'b1, 4'h3, 4'hA, 4'h7);
    do_access("p0_rd3", 1'b0, 1'b0, 4'h3, 4'h0, 4'hA);
    do_access("p1_wr2", 1'b1, 1'b1, 4'h2, 4'h5, 4'h0);
    do_access("p1_wr9", 1'b1, 1'b1, 4'h9, 4'hC, 4'h0);

    // Request withdrawn during ACCESS still completes, no repeat.
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h3;
    @(negedge clk);
    chk1("wd_acc_cs", ram_cs, 1'b1);
    chk4("wd_acc_addr", ram_addr, 4'h3);
    req1 = 1'b0;
    @(negedge clk);
    chk1("wd_done1", done1, 1'b1);
    chk4("wd_rdata1", rdata1, 4'hA);
    @(negedge clk);
    chk_idle("wd_idle_a");
    @(negedge clk);
    chk_idle("wd_idle_b");

    // Continuous contention for 12 cycles: grants 0,1,0,1.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h1;
    for (int k = 1; k <= 12; k++) begin
      int  phase;
      bit  port;
      @(negedge clk);
      phase = k % 3;
      port  = 1'(((k - 1) / 3) % 2);
      chk1("ct_cs", ram_cs, 1'(phase == 1));
      chk1("ct_done0", done0, 1'(phase == 2 && !port));
      chk1("ct_done1", done1, 1'(phase == 2 && port));
      chk1("ct_both", done0 & done1, 1'b0);
      if (phase == 1) chk4("ct_addr", ram_addr, port ? 4'h1 : 4'h3);
      if (phase == 2) chk4("ct_rdata", port ? rdata1 : rdata0, port ? 4'h7 : 4'hA);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk_idle("ct_after");

    // Input churn during ACCESS is ignored.
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h2;
    @(negedge clk);
    chk4("ch_acc_addr", ram_addr, 4'h2);
    chk1("ch_acc_we", ram_write_en, 1'b1);
    addr0 = 4'h9; we0 = 1'b1; wdata0 = 4'hF;
    @(negedge clk);
    chk1("ch_done0", done0, 1'b1);
    chk4("ch_rdata0", rdata0, 4'h5);
    chk4("ch_rsp_addr", ram_addr, 4'h2);
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk_idle("ch_idle");
    chk4("ch_mem9", 4'(mem[9]), 4'hC);

    // Asynchronous reset in the middle of a write ACCESS aborts it.
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h5; wdata0 = 4'hF;
    @(negedge clk);
    chk1("rs_acc_cs", ram_cs, 1'b1);
    chk1("rs_acc_we", ram_write_en, 1'b0);
    chk4("rs_acc_addr", ram_addr, 4'h5);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rs_async");
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk_reset_vals("rs_held");
    chk4("rs_mem5", 4'(mem[5]), 4'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rs_rel_a");
    @(negedge clk);
    chk_idle("rs_rel_b");
    chk4("rs_mem5_after", 4'(mem[5]), 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
